// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
// Default geometry, FSM state encoding and a packed-port slicing helper.
// No timing behaviour of its own.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Low bit of port `port` inside a bus packing ports of `width` bits each.
  function automatic int rf_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: picks zero, forwarded write data or the stored row.
// Latency: purely combinational.
// Backpressure: none; reads 0 whenever the file is not READY.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] row,
  input  logic            wr_live,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  rf_state_t       state,
  output logic [XLEN-1:0] data
);

  // Zero-register test comes first, so a forwarded write never targets r0.
  always_comb begin
    data = row;
    if (state != RF_READY) begin
      data = '0;
    end else if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end else if ((BYPASS != 0) && wr_live && (wr_addr == addr)) begin
      data = wr_data;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// N-read / 1-write register file with bypass, zero register and sequenced clear.
// Latency: reads combinational; clear holds ready low for NREGS cycles.
// Backpressure: ready=0 during clear; writes dropped, reads return 0.
module register_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN     = RF_XLEN,
  parameter int NREGS    = RF_NREGS,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  ready
);

  rf_state_t       state;
  rf_state_t       state_nxt;
  logic [AW-1:0]   clr_idx;
  logic            clr_we;
  logic            wr_live;
  logic            wr_we;
  logic [XLEN-1:0] rf [NREGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RF_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RF_CLEAR: if (clr_idx == AW'(NREGS - 1)) state_nxt = RF_READY;
      RF_READY: if (clear_req) state_nxt = RF_CLEAR;
      default:  state_nxt = RF_CLEAR;
    endcase
  end

  // A clear request in the same cycle kills both the write and its bypass.
  always_comb begin
    ready   = (state == RF_READY);
    clr_we  = (state == RF_CLEAR) && !reset;
    wr_live = ready && wr_en && !clear_req;
    wr_we   = wr_live && !reset && !((ZERO_REG != 0) && (wr_addr == '0));
  end

  // Counter idles at 0 outside CLEAR, so every clear starts from r0.
  always_ff @(posedge clock) begin
    if (reset || (state != RF_CLEAR)) begin
      clr_idx <= '0;
    end else begin
      clr_idx <= clr_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (clr_we) begin
      rf[clr_idx] <= '0;
    end else if (wr_we) begin
      rf[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] port_addr;
    assign port_addr = rd_addr[rf_lo(i, AW) +: AW];

    rf_read_port #(
      .XLEN     (XLEN),
      .AW       (AW),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .addr    (port_addr),
      .row     (rf[port_addr]),
      .wr_live (wr_live),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .state   (state),
      .data    (rd_data[rf_lo(i, XLEN) +: XLEN])
    );
  end

endmodule
